mips_harvard_mem_checker: RTL and testbench



---
 rtl/mips_harvard_mem_checker_pkg.sv | 20 ++
 rtl/mips_harvard_mem_checker_if.sv | 11 +
 rtl/mips_harvard_mem_checker_seq.sv | 51 +++++
 rtl/mips_harvard_mem_checker.sv | 188 ++++++++++++++++++
 tb/tb_mips_harvard_mem_checker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_harvard_mem_checker_pkg.sv
// Shared types and helpers for the post-run data-memory checker.
// Holds the FSM state encoding, the word size and the byte-order swap.
package mips_tb_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_RUN        = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_CHECK      = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  // RAM words are stored little-endian relative to the CPU's view.
  function automatic logic [31:0] reverse_endian(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_harvard_mem_checker_if.sv
// Data-port bus between CPU, checker and data RAM.
// The RAM returns readdata combinationally in the same cycle.
interface mips_harvard_mem_checker_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] readdata;

  modport master (output address, output read, output write, input readdata);
  modport slave  (input address, input read, input write, output readdata);
endinterface

// File: rtl/mips_harvard_mem_checker_seq.sv
// Expected-value generator: arithmetic sequence plus word index.
// load restarts the sequence, step advances both value and index.
module mips_seq_gen #(
  parameter logic [31:0] SEQ_START = 32'h12345678,
  parameter logic [31:0] SEQ_STEP  = 32'hdcba1234,
  parameter int          NUM_WORDS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] expected_o,
  output logic [7:0]  index_o,
  output logic        last_o
);

  logic [31:0] expected_q, expected_d;
  logic [7:0]  index_q, index_d;

  // next expected value and index
  always_comb begin
    expected_d = expected_q;
    index_d    = index_q;
    if (load_i) begin
      expected_d = SEQ_START;
      index_d    = 8'd0;
    end else if (step_i) begin
      expected_d = expected_q + SEQ_STEP;
      index_d    = index_q + 8'd1;
    end else begin
      expected_d = expected_q;
      index_d    = index_q;
    end
  end

  // sequence registers
  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q <= SEQ_START;
      index_q    <= 8'd0;
    end else begin
      expected_q <= expected_d;
      index_q    <= index_d;
    end
  end

  assign expected_o = expected_q;
  assign index_o    = index_q;
  assign last_o     = (index_q == 8'(NUM_WORDS - 1));

endmodule

// File: rtl/mips_harvard_mem_checker.sv
// Post-run checker between the CPU data port and the data RAM: passes the bus
// through while the CPU runs, then walks a word region against a sequence.
module mips_harvard_mem_checker
  import mips_tb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h100,
  parameter int          NUM_WORDS = 14,
  parameter logic [31:0] SEQ_START = 32'h12345678,
  parameter logic [31:0] SEQ_STEP  = 32'hdcba1234,
  parameter logic [31:0] OR_MASK   = 32'h0000000F,
  parameter int          TIMEOUT   = 5000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cpu_active,
  mips_harvard_mem_checker_if.slave      cpu_bus,
  mips_harvard_mem_checker_if.master     mem_bus,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [7:0]                     error_count,
  output logic [31:0]                    fail_addr,
  output logic [31:0]                    fail_data
);

  state_e      state_q, state_d;
  logic [31:0] counter_q, counter_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] fail_addr_q, fail_addr_d;
  logic [31:0] fail_data_q, fail_data_d;

  logic        seq_load_s, seq_step_s, seq_last_s;
  logic [31:0] expected_s;
  logic [7:0]  index_s;
  logic [31:0] check_addr_s;
  logic [31:0] swapped_s;
  logic        mismatch_s;

  mips_seq_gen #(
    .SEQ_START (SEQ_START),
    .SEQ_STEP  (SEQ_STEP),
    .NUM_WORDS (NUM_WORDS)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .load_i     (seq_load_s),
    .step_i     (seq_step_s),
    .expected_o (expected_s),
    .index_o    (index_s),
    .last_o     (seq_last_s)
  );

  assign check_addr_s = BASE_ADDR + ({24'd0, index_s} * WORD_BYTES);
  assign swapped_s    = reverse_endian(mem_bus.readdata);
  assign mismatch_s   = (swapped_s != (expected_s | OR_MASK));

  // next state, counters and result registers
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    seq_load_s  = 1'b0;
    seq_step_s  = 1'b0;
    case (state_q)
      ST_WAIT_START: begin
        seq_load_s = 1'b1;
        if (cpu_active) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_RUN: begin
        counter_d = counter_q + 32'd1;
        if (!cpu_active) begin
          state_d = ST_SETTLE;
        end else if (counter_q == 32'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SETTLE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        seq_step_s = 1'b1;
        if (mismatch_s) begin
          if (err_q != 8'd255) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
          if (err_q == 8'd0) begin
            fail_addr_d = check_addr_s;
            fail_data_d = swapped_s;
          end else begin
            fail_addr_d = fail_addr_q;
            fail_data_d = fail_data_q;
          end
        end else begin
          err_d = err_q;
        end
        if (seq_last_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0) && !timeout_q;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT_START;
      end
    endcase
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_START;
      counter_q   <= 32'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= 32'd0;
      fail_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // bus ownership: CPU until it stops, checker reads during CHECK, idle otherwise
  always_comb begin
    mem_bus.address = 32'd0;
    mem_bus.read    = 1'b0;
    mem_bus.write   = 1'b0;
    case (state_q)
      ST_WAIT_START, ST_RUN: begin
        mem_bus.address = cpu_bus.address;
        mem_bus.read    = cpu_bus.read;
        mem_bus.write   = cpu_bus.write;
      end
      ST_CHECK: begin
        mem_bus.address = check_addr_s;
        mem_bus.read    = 1'b1;
        mem_bus.write   = 1'b0;
      end
      default: begin
        mem_bus.address = 32'd0;
        mem_bus.read    = 1'b0;
        mem_bus.write   = 1'b0;
      end
    endcase
  end

  assign cpu_bus.readdata = mem_bus.readdata;

  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign error_count = err_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mips_harvard_mem_checker.sv
// Scoreboard bench for mips_harvard_mem_checker: stimulus queues the expected
// result of each run, a monitor compares when done rises.
module tb_mips_harvard_mem_checker;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [7:0]  err;
    logic [31:0] fa;
    logic [31:0] fd;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic cpu_active;
  logic done, pass, timeout;
  logic [7:0]  error_count;
  logic [31:0] fail_addr, fail_data;

  mips_harvard_mem_checker_if cpu_if ();
  mips_harvard_mem_checker_if mem_if ();

  logic [31:0] ram [0:255];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   rd_cnt   = 0;
  logic done_prev = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign mem_if.readdata = ram[mem_if.address[9:2]];

  mips_harvard_mem_checker dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_active  (cpu_active),
    .cpu_bus     (cpu_if),
    .mem_bus     (mem_if),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .error_count (error_count),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_if.read) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] good_word(input int k);
    return swap32((32'h12345678 + 32'(k) * 32'hdcba1234) | 32'h0000000F);
  endfunction

  // monitor: compare the queued expectation when done rises
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result");
      end else begin
        e = exp_q.pop_front();
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
        chk("error_count", {24'd0, error_count}, {24'd0, e.err});
        chk("fail_addr", fail_addr, e.fa);
        chk("fail_data", fail_data, e.fd);
        if (e.lat >= 0) chk("latency", 32'(cyc - fall_cyc + 1), 32'(e.lat));
      end
    end
    done_prev = done;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_good();
    for (int k = 0; k < 14; k++) ram[8'h40 + k] = good_word(k);
  endtask

  // keep CPU active for n cycles, queue the expectation, then release and wait
  task automatic finish_run(input int n, input exp_t e);
    bit seen = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.push_back(e);
    cpu_active = 1'b0;
    fall_cyc = cyc + 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    exp_t e;
    bit   hit;
    reset = 1'b1;
    cpu_active = 1'b0;
    cpu_if.address = 32'd0;
    cpu_if.read = 1'b0;
    cpu_if.write = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    load_good();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_err", {24'd0, error_count}, 32'd0);
    chk("rst_fail_addr", fail_addr, 32'd0);
    chk("rst_fail_data", fail_data, 32'd0);

    // passthrough while waiting for start, including read data back to CPU
    cpu_if.address = 32'h104;
    cpu_if.read = 1'b1;
    #1;
    chk("wait_addr", mem_if.address, 32'h104);
    chk("wait_read", {31'd0, mem_if.read}, 32'd1);
    chk("wait_rdata", cpu_if.readdata, good_word(1));
    cpu_if.read = 1'b0;
    cpu_if.address = 32'd0;

    // clean run with a CPU write during RUN
    @(negedge clk);
    cpu_active = 1'b1;
    @(negedge clk);
    cpu_if.address = 32'h200;
    cpu_if.write = 1'b1;
    #1;
    chk("run_wr_addr", mem_if.address, 32'h200);
    chk("run_wr_strobe", {31'd0, mem_if.write}, 32'd1);
    @(negedge clk);
    cpu_if.write = 1'b0;
    cpu_if.address = 32'd0;
    e = '{pass: 1'b1, tmo: 1'b0, err: 8'd0, fa: 32'd0, fd: 32'd0, lat: 16};
    finish_run(18, e);

    // single corrupted word 5
    do_reset();
    ram[8'h45] = 32'd0;
    cpu_active = 1'b1;
    e = '{pass: 1'b0, tmo: 1'b0, err: 8'd1, fa: 32'h114, fd: 32'd0, lat: 16};
    finish_run(20, e);

    // words 2 and 9 corrupted: only the first is latched
    do_reset();
    load_good();
    ram[8'h42] = 32'h11223344;
    ram[8'h49] = 32'd0;
    cpu_active = 1'b1;
    e = '{pass: 1'b0, tmo: 1'b0, err: 8'd2, fa: 32'h108, fd: 32'h44332211, lat: 16};
    finish_run(20, e);

    // reset while word 7 is being read: one error already counted
    do_reset();
    cpu_active = 1'b1;
    repeat (10) @(negedge clk);
    cpu_active = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = mem_if.read && (mem_if.address == 32'h11C);
    end
    chk("word7_seen", {31'd0, hit}, 32'd1);
    chk("mid_err", {24'd0, error_count}, 32'd1);
    reset = 1'b1;
    cpu_if.address = 32'h40;
    cpu_if.read = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {24'd0, error_count}, 32'd0);
    chk("abort_fail_addr", fail_addr, 32'd0);
    chk("abort_addr", mem_if.address, 32'h40);
    chk("abort_read", {31'd0, mem_if.read}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cpu_if.read = 1'b0;
    cpu_if.address = 32'd0;

    // timeout: CPU never stops
    do_reset();
    load_good();
    rd_cnt = 0;
    cpu_active = 1'b1;
    e = '{pass: 1'b0, tmo: 1'b1, err: 8'd0, fa: 32'd0, fd: 32'd0, lat: -1};
    exp_q.push_back(e);
    hit = 1'b0;
    for (int i = 0; i < 5100 && !hit; i++) begin
      @(negedge clk);
      hit = done;
    end
    chk("timeout_done", {31'd0, hit}, 32'd1);
    cpu_active = 1'b0;
    repeat (20) @(negedge clk);
    chk("timeout_no_reads", 32'(rd_cnt), 32'd0);
    chk("timeout_done_held", {31'd0, done}, 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
